// File: rtl/interval_timer_sched.sv
// interval_timer_sched
// Round-robin owner of one shared down-counter. A winning requester has
// its delay loaded and counted down to zero. It then gets a one-cycle
// done pulse, and the grant rotates past it. All outputs are registered.
module interval_timer_sched #(
    parameter int P_NUM_REQ = 4,
    parameter int P_COUNT_W = 16
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [P_NUM_REQ-1:0]           i_req,
    input  logic [P_NUM_REQ*P_COUNT_W-1:0] i_load,
    output logic [P_NUM_REQ-1:0]           o_grant,
    output logic [P_NUM_REQ-1:0]           o_done,
    output logic                           o_busy,
    output logic [P_COUNT_W-1:0]           o_count
);

    localparam int P_PTR_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_next;
    logic [P_PTR_W-1:0]   ptr_q, ptr_next;
    logic [P_PTR_W-1:0]   winner_q, winner_next;
    logic [P_NUM_REQ-1:0] grant_next, done_next;
    logic [P_COUNT_W-1:0] count_next;

    logic                 arb_found;
    logic [P_PTR_W-1:0]   arb_idx;
    logic [P_NUM_REQ-1:0] arb_onehot;
    logic [P_COUNT_W-1:0] arb_load;
    logic [P_PTR_W-1:0]   winner_inc;
    int                   cand;

    // Scan requests starting at the rotating pointer, wrapping past the top index.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_onehot = '0;
        arb_load   = '0;
        cand       = 0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= P_NUM_REQ) begin
                cand = cand - P_NUM_REQ;
            end
            if (!arb_found && i_req[cand]) begin
                arb_found        = 1'b1;
                arb_idx          = P_PTR_W'(cand);
                arb_onehot[cand] = 1'b1;
                arb_load         = i_load[cand*P_COUNT_W +: P_COUNT_W];
            end
        end
    end

    // Pointer position just after the current owner, used whenever a grant ends.
    always_comb begin
        if (winner_q == P_PTR_W'(P_NUM_REQ - 1)) begin
            winner_inc = '0;
        end else begin
            winner_inc = winner_q + P_PTR_W'(1);
        end
    end

    // Next-state and next-output decisions for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_next  = state_q;
        ptr_next    = ptr_q;
        winner_next = winner_q;
        grant_next  = o_grant;
        done_next   = '0;
        count_next  = o_count;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_next  = RUN;
                    winner_next = arb_idx;
                    grant_next  = arb_onehot;
                    count_next  = arb_load;
                end
            end
            RUN: begin
                // An owner dropping its request abandons the delay without a pulse.
                if ((i_req & o_grant) == '0) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = winner_inc;
                end else if (o_count != '0) begin
                    count_next = o_count - P_COUNT_W'(1);
                end else begin
                    done_next  = o_grant;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                grant_next = '0;
                ptr_next   = winner_inc;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any grant in progress.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            o_grant  <= '0;
            o_done   <= '0;
            o_count  <= '0;
        end else begin
            state_q  <= state_next;
            ptr_q    <= ptr_next;
            winner_q <= winner_next;
            o_grant  <= grant_next;
            o_done   <= done_next;
            o_count  <= count_next;
        end
    end

    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_interval_timer_sched.sv
// tb_interval_timer_sched
// Directed table of per-cycle vectors for the 16-bit scheduler, plus a
// hand-written full-range run on a 4-bit instance.
module tb_interval_timer_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] load;
    logic [3:0]  grant, done;
    logic        busy;
    logic [15:0] count;

    logic [3:0]  req4;
    logic [15:0] load4;
    logic [3:0]  grant4, done4;
    logic        busy4;
    logic [3:0]  count4;

    int n_cmp;
    int n_fail;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [3:0]  req;
        logic [63:0] load;
        logic [3:0]  exp_grant;
        logic [3:0]  exp_done;
        logic        exp_busy;
        logic [15:0] exp_count;
        logic        chk_count;
    } vec_t;

    vec_t vecs[$];

    interval_timer_sched #(.P_NUM_REQ(4), .P_COUNT_W(16)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_req     (req),
        .i_load    (load),
        .o_grant   (grant),
        .o_done    (done),
        .o_busy    (busy),
        .o_count   (count)
    );

    interval_timer_sched #(.P_NUM_REQ(4), .P_COUNT_W(4)) dut_w4 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_req     (req4),
        .i_load    (load4),
        .o_grant   (grant4),
        .o_done    (done4),
        .o_busy    (busy4),
        .o_count   (count4)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] packLoads(input logic [15:0] l3, input logic [15:0] l2,
                                              input logic [15:0] l1, input logic [15:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic addVec(input string name, input logic r, input logic [3:0] q,
                          input logic [63:0] l, input logic [3:0] g, input logic [3:0] d,
                          input logic b, input logic [15:0] c, input logic cc);
        vec_t v;
        v.name = name; v.rst_n = r; v.req = q; v.load = l;
        v.exp_grant = g; v.exp_done = d; v.exp_busy = b; v.exp_count = c; v.chk_count = cc;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] q, input logic [63:0] l);
        rst_n = r;
        req   = q;
        load  = l;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        logic [63:0] ld;
        logic [3:0]  oh;
        int          order_a[5];
        int          order_b[4];
        n_cmp  = 0;
        n_fail = 0;
        order_a = '{0, 1, 2, 3, 0};
        order_b = '{1, 3, 1, 3};

        // Single request, delay 3; load changed after grant must be ignored.
        ld = packLoads(16'd0, 16'd0, 16'd3, 16'd0);
        addVec("reset",        1'b0, 4'b0000, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);
        addVec("t1_grant",     1'b1, 4'b0010, ld, 4'b0010, 4'b0000, 1'b1, 16'd3, 1'b1);
        addVec("t1_cnt2",      1'b1, 4'b0010, packLoads(16'd0, 16'd0, 16'd9, 16'd0),
                                                  4'b0010, 4'b0000, 1'b1, 16'd2, 1'b1);
        addVec("t1_cnt1",      1'b1, 4'b0010, ld, 4'b0010, 4'b0000, 1'b1, 16'd1, 1'b1);
        addVec("t1_cnt0",      1'b1, 4'b0010, ld, 4'b0010, 4'b0000, 1'b1, 16'd0, 1'b1);
        addVec("t1_done",      1'b1, 4'b0010, ld, 4'b0010, 4'b0010, 1'b1, 16'd0, 1'b1);
        addVec("t1_idle",      1'b1, 4'b0000, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);

        // Zero delay: done on the cycle right after the grant.
        ld = packLoads(16'd0, 16'd0, 16'd0, 16'd0);
        addVec("t2_grant",     1'b1, 4'b0001, ld, 4'b0001, 4'b0000, 1'b1, 16'd0, 1'b1);
        addVec("t2_done",      1'b1, 4'b0001, ld, 4'b0001, 4'b0001, 1'b1, 16'd0, 1'b1);
        addVec("t2_idle",      1'b1, 4'b0000, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);

        // Round robin over all four, then over requesters 1 and 3.
        addVec("t3_reset",     1'b0, 4'b0000, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);
        ld = packLoads(16'd1, 16'd1, 16'd1, 16'd1);
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << order_a[i];
            addVec($sformatf("t3a_grant%0d", i), 1'b1, 4'b1111, ld, oh, 4'b0000, 1'b1, 16'd1, 1'b1);
            addVec($sformatf("t3a_cnt%0d", i),   1'b1, 4'b1111, ld, oh, 4'b0000, 1'b1, 16'd0, 1'b1);
            addVec($sformatf("t3a_done%0d", i),  1'b1, 4'b1111, ld, oh, oh,      1'b1, 16'd0, 1'b1);
            addVec($sformatf("t3a_idle%0d", i),  1'b1, 4'b1111 & ~oh, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << order_b[i];
            addVec($sformatf("t3b_grant%0d", i), 1'b1, 4'b1010, ld, oh, 4'b0000, 1'b1, 16'd1, 1'b1);
            addVec($sformatf("t3b_cnt%0d", i),   1'b1, 4'b1010, ld, oh, 4'b0000, 1'b1, 16'd0, 1'b1);
            addVec($sformatf("t3b_done%0d", i),  1'b1, 4'b1010, ld, oh, oh,      1'b1, 16'd0, 1'b1);
            addVec($sformatf("t3b_idle%0d", i),  1'b1, 4'b1010 & ~oh, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);
        end

        // Abort at count 6; pointer then sits at 3 and wraps to requester 0.
        ld = packLoads(16'd0, 16'd10, 16'd0, 16'd2);
        addVec("t4_grant",     1'b1, 4'b0100, ld, 4'b0100, 4'b0000, 1'b1, 16'd10, 1'b1);
        for (int k = 9; k >= 6; k--) begin
            addVec($sformatf("t4_cnt%0d", k), 1'b1, 4'b0100, ld, 4'b0100, 4'b0000, 1'b1, 16'(k), 1'b1);
        end
        addVec("t4_abort",     1'b1, 4'b0000, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b0);
        addVec("t4_regrant",   1'b1, 4'b0101, ld, 4'b0001, 4'b0000, 1'b1, 16'd2, 1'b1);
        addVec("t4_cnt1",      1'b1, 4'b0101, ld, 4'b0001, 4'b0000, 1'b1, 16'd1, 1'b1);
        addVec("t4_cnt0",      1'b1, 4'b0101, ld, 4'b0001, 4'b0000, 1'b1, 16'd0, 1'b1);
        addVec("t4_done",      1'b1, 4'b0101, ld, 4'b0001, 4'b0001, 1'b1, 16'd0, 1'b1);
        addVec("t4_idle",      1'b1, 4'b0100, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);

        // Reset mid-run clears everything and returns the pointer to 0.
        ld = packLoads(16'd7, 16'd0, 16'd0, 16'd1);
        addVec("t5_grant",     1'b1, 4'b1000, ld, 4'b1000, 4'b0000, 1'b1, 16'd7, 1'b1);
        addVec("t5_cnt6",      1'b1, 4'b1000, ld, 4'b1000, 4'b0000, 1'b1, 16'd6, 1'b1);
        addVec("t5_cnt5",      1'b1, 4'b1000, ld, 4'b1000, 4'b0000, 1'b1, 16'd5, 1'b1);
        addVec("t5_reset",     1'b0, 4'b1000, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);
        addVec("t5_regrant",   1'b1, 4'b1001, ld, 4'b0001, 4'b0000, 1'b1, 16'd1, 1'b1);
        addVec("t5_cnt0",      1'b1, 4'b1001, ld, 4'b0001, 4'b0000, 1'b1, 16'd0, 1'b1);
        addVec("t5_done",      1'b1, 4'b1001, ld, 4'b0001, 4'b0001, 1'b1, 16'd0, 1'b1);
        addVec("t5_idle",      1'b1, 4'b1000, ld, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);
        addVec("t5_next",      1'b1, 4'b1000, ld, 4'b1000, 4'b0000, 1'b1, 16'd7, 1'b1);

        rst_n = 1'b0;
        req   = '0;
        load  = '0;
        req4  = '0;
        load4 = '0;
        @(negedge clk);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].req, vecs[i].load);
            @(negedge clk);
            checkOutput({vecs[i].name, ".grant"}, 32'(grant), 32'(vecs[i].exp_grant));
            checkOutput({vecs[i].name, ".done"},  32'(done),  32'(vecs[i].exp_done));
            checkOutput({vecs[i].name, ".busy"},  32'(busy),  32'(vecs[i].exp_busy));
            if (vecs[i].chk_count) begin
                checkOutput({vecs[i].name, ".count"}, 32'(count), 32'(vecs[i].exp_count));
            end
        end
        req = 4'b0000;

        // Full-range delay on the 4-bit instance: 15 down to 0 without wrapping.
        req4  = 4'b0001;
        load4 = 16'hFFFF;
        @(negedge clk);
        checkOutput("t6_grant", 32'(grant4), 32'h1);
        checkOutput("t6_cnt15", 32'(count4), 32'd15);
        for (int k = 14; k >= 0; k--) begin
            @(negedge clk);
            checkOutput($sformatf("t6_cnt%0d", k), 32'(count4), 32'(k));
            checkOutput($sformatf("t6_nodone%0d", k), 32'(done4), 32'h0);
        end
        @(negedge clk);
        checkOutput("t6_done",      32'(done4),  32'h1);
        checkOutput("t6_done_cnt",  32'(count4), 32'd0);
        req4 = 4'b0000;
        @(negedge clk);
        checkOutput("t6_idle_busy",  32'(busy4),  32'h0);
        checkOutput("t6_idle_grant", 32'(grant4), 32'h0);
        checkOutput("t6_idle_done",  32'(done4),  32'h0);
        checkOutput("t6_idle_cnt",   32'(count4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
